// File: rtl/keypad_scanner_n_if.sv
// keypad_scanner_n_if: key event bus (valid/ready event plus sticky overflow) from scanner to consumer.
interface keypad_scanner_n_if #(
   parameter int NUM_ROWS = 4,
   parameter int NUM_COLS = 4
);
   localparam int RW = (NUM_ROWS > 2) ? $clog2(NUM_ROWS) : 1;
   localparam int CW = (NUM_COLS > 2) ? $clog2(NUM_COLS) : 1;
   logic          key_valid;
   logic          key_ready;
   logic [RW-1:0] key_row;
   logic [CW-1:0] key_col;
   logic          key_release;
   logic          overflow;
   modport master (output key_valid, key_row, key_col, key_release, overflow, input key_ready);
   modport slave  (input key_valid, key_row, key_col, key_release, overflow, output key_ready);
endinterface

// File: rtl/keypad_scanner_n.sv
// keypad_scanner_n: debounced NUM_ROWS x NUM_COLS keypad scanner delivering valid/ready key events.
// Define RELEASE_EVENT_EN to also emit release events (key_release=1).
module keypad_scanner_n #(
   parameter int NUM_ROWS        = 4,
   parameter int NUM_COLS        = 4,
   parameter int SCAN_DIV        = 4,
   parameter int DEBOUNCE_CYCLES = 8
) (
   input  logic                clk,
   input  logic                reset,
   input  logic [NUM_ROWS-1:0] rows,
   output logic [NUM_COLS-1:0] cols,
   keypad_scanner_n_if.master  key
);
   localparam int RW = (NUM_ROWS > 2) ? $clog2(NUM_ROWS) : 1;
   localparam int CW = (NUM_COLS > 2) ? $clog2(NUM_COLS) : 1;
   localparam int DW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
   localparam int BW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [1:0] SCAN = 2'd0, PRESS_DB = 2'd1, HELD = 2'd2, REL_DB = 2'd3;

   logic [NUM_ROWS-1:0] sync_q, srows_q, pat_q, pat_d;
   logic [1:0]          state_q, state_d;
   logic [CW-1:0]       col_q, col_d, col_nxt, key_col_q, key_col_d;
   logic [NUM_COLS-1:0] cols_q, cols_d;
   logic [DW-1:0]       dwell_q, dwell_d;
   logic [BW-1:0]       db_q, db_d;
   logic [RW-1:0]       row_q, row_d, hit_row, key_row_q, key_row_d;
   logic                key_valid_q, key_valid_d, overflow_q, overflow_d, ev, load;
`ifdef RELEASE_EVENT_EN
   logic                ev_rel, key_release_q, key_release_d;
`endif

   always_comb begin
      hit_row = '0;
      for (int i = 0; i < NUM_ROWS; i++)
         if (srows_q[i]) hit_row = RW'(i);
   end

   assign col_nxt = (col_q == CW'(NUM_COLS - 1)) ? '0 : col_q + 1'b1;

   always_comb begin
      state_d = state_q;
      col_d   = col_q;
      dwell_d = dwell_q;
      db_d    = db_q;
      row_d   = row_q;
      pat_d   = pat_q;
      ev      = 1'b0;
`ifdef RELEASE_EVENT_EN
      ev_rel  = 1'b0;
`endif
      case (state_q)
         SCAN:
            if (dwell_q == DW'(SCAN_DIV - 1)) begin
               dwell_d = '0;
               if ($onehot(srows_q)) begin
                  state_d = PRESS_DB;
                  row_d   = hit_row;
                  pat_d   = srows_q;
                  db_d    = '0;
               end else col_d = col_nxt;
            end else dwell_d = dwell_q + 1'b1;
         PRESS_DB:
            if (srows_q != pat_q) begin
               state_d = SCAN;
               col_d   = col_nxt;
               dwell_d = '0;
            end else if (db_q == BW'(DEBOUNCE_CYCLES - 1)) begin
               state_d = HELD;
               ev      = 1'b1;
            end else db_d = db_q + 1'b1;
         HELD:
            if (!srows_q[row_q]) begin
               state_d = REL_DB;
               db_d    = '0;
            end
         default:
            if (srows_q[row_q]) state_d = HELD;
            else if (db_q == BW'(DEBOUNCE_CYCLES - 1)) begin
               state_d = SCAN;
               col_d   = col_nxt;
               dwell_d = '0;
`ifdef RELEASE_EVENT_EN
               ev      = 1'b1;
               ev_rel  = 1'b1;
`endif
            end else db_d = db_q + 1'b1;
      endcase
   end

   // An event arriving while the previous one is stalled is dropped; one arriving on the transfer cycle replaces it.
   always_comb begin
      cols_d      = {{(NUM_COLS-1){1'b0}}, 1'b1} << col_d;
      load        = ev & (~key_valid_q | key.key_ready);
      key_valid_d = load | (key_valid_q & ~key.key_ready);
      overflow_d  = overflow_q | (ev & key_valid_q & ~key.key_ready);
      key_row_d   = load ? row_q : key_row_q;
      key_col_d   = load ? col_q : key_col_q;
`ifdef RELEASE_EVENT_EN
      key_release_d = load ? ev_rel : key_release_q;
`endif
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q      <= '0;
         srows_q     <= '0;
         state_q     <= SCAN;
         col_q       <= '0;
         cols_q      <= {{(NUM_COLS-1){1'b0}}, 1'b1};
         dwell_q     <= '0;
         db_q        <= '0;
         row_q       <= '0;
         pat_q       <= '0;
         key_valid_q <= 1'b0;
         key_row_q   <= '0;
         key_col_q   <= '0;
         overflow_q  <= 1'b0;
      end else begin
         sync_q      <= rows;
         srows_q     <= sync_q;
         state_q     <= state_d;
         col_q       <= col_d;
         cols_q      <= cols_d;
         dwell_q     <= dwell_d;
         db_q        <= db_d;
         row_q       <= row_d;
         pat_q       <= pat_d;
         key_valid_q <= key_valid_d;
         key_row_q   <= key_row_d;
         key_col_q   <= key_col_d;
         overflow_q  <= overflow_d;
      end
   end

`ifdef RELEASE_EVENT_EN
   always_ff @(posedge clk) key_release_q <= reset ? 1'b0 : key_release_d;
   assign key.key_release = key_release_q;
`else
   assign key.key_release = 1'b0;
`endif
   assign cols          = cols_q;
   assign key.key_valid = key_valid_q;
   assign key.key_row   = key_row_q;
   assign key.key_col   = key_col_q;
   assign key.overflow  = overflow_q;
endmodule

// File: tb/tb_keypad_scanner_n.sv
// tb_keypad_scanner_n: scoreboard bench; a keypad model connects pressed keys from cols to rows.
module tb_keypad_scanner_n;
   typedef struct packed {logic [1:0] r; logic [1:0] c; logic rel;} ev_t;

   logic            clk = 1'b0;
   logic            reset = 1'b1;
   logic [3:0]      rows, cols;
   logic [3:0][3:0] keys = '0;
   logic            bounce = 1'b0;
   ev_t             exp_q[$];
   int              tests = 0, fails = 0, ev_seen = 0, nexp = 0;

   keypad_scanner_n_if #(.NUM_ROWS(4), .NUM_COLS(4)) kif ();
   keypad_scanner_n #(.NUM_ROWS(4), .NUM_COLS(4), .SCAN_DIV(4), .DEBOUNCE_CYCLES(8)) dut (
      .clk(clk), .reset(reset), .rows(rows), .cols(cols), .key(kif));

   always #5 clk = ~clk;

   always_comb
      for (int r = 0; r < 4; r++) rows[r] = ~bounce & |(keys[r] & cols);

   task automatic chk(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   always @(negedge clk)
      if (!reset && kif.key_valid && kif.key_ready) begin : mon
         ev_t e;
         ev_seen++;
         if (exp_q.size() == 0) chk("unexpected_event", 1, 0);
         else begin
            e = exp_q.pop_front();
            chk("ev_row", kif.key_row, e.r);
            chk("ev_col", kif.key_col, e.c);
            chk("ev_release", kif.key_release, e.rel);
         end
      end

   task automatic tick(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_cols(logic [3:0] v, int budget);
      int k = 0;
      while (cols !== v && k < budget) begin @(negedge clk); k++; end
      chk("wait_cols", cols, v);
   endtask

   task automatic wait_change(logic [3:0] from, output int n);
      n = 0;
      while (cols === from && n < 100) begin @(negedge clk); n++; end
   endtask

   task automatic wait_ev(int n, int budget);
      int k = 0;
      while (ev_seen < n && k < budget) begin @(negedge clk); k++; end
      chk("event_count", ev_seen, n);
   endtask

   task automatic set_ready(logic v);
      @(posedge clk);
      #2 kif.key_ready = v;
   endtask

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1);
   end

   initial begin
      int n;
      kif.key_ready = 1'b1;
      tick(3);
      reset = 1'b0;
      tick(6);
      reset = 1'b1;
      tick(2);
      chk("reset_cols", cols, 4'b0001);
      chk("reset_valid", kif.key_valid, 0);
      chk("reset_overflow", kif.overflow, 0);
      chk("reset_row", kif.key_row, 0);
      reset = 1'b0;

      // press (2,1), hold, release
      wait_cols(4'b0001, 40);
      keys[2] = 4'b0010;
      exp_q.push_back('{r: 2'd2, c: 2'd1, rel: 1'b0});
      nexp++;
      wait_ev(nexp, 80);
      tick(10);
      chk("cols_held", cols, 4'b0010);
      tick(10);
      chk("cols_held2", cols, 4'b0010);
`ifdef RELEASE_EVENT_EN
      exp_q.push_back('{r: 2'd2, c: 2'd1, rel: 1'b1});
      nexp++;
`endif
      keys[2] = 4'b0000;
      wait_change(4'b0010, n);
      chk("release_next_col", cols, 4'b0100);
      chk("release_debounce_len", int'(n >= 10 && n <= 13), 1);
      wait_ev(nexp, 10);

      // bounce at debounce count 5
      wait_cols(4'b0001, 40);
      keys[2] = 4'b0010;
      wait_cols(4'b0010, 10);
      tick(7);
      bounce = 1'b1;
      tick(1);
      bounce = 1'b0;
      wait_change(4'b0010, n);
      keys[2] = 4'b0000;
      chk("bounce_next_col", cols, 4'b0100);
      chk("bounce_abort_time", int'(n <= 4), 1);
      chk("bounce_no_event", ev_seen, nexp);

      // overflow: A held unaccepted, B dropped
      wait_cols(4'b0001, 40);
      set_ready(1'b0);
      keys[1] = 4'b0001;
      exp_q.push_back('{r: 2'd1, c: 2'd0, rel: 1'b0});
      nexp++;
      n = 0;
      while (!kif.key_valid && n < 80) begin @(negedge clk); n++; end
      chk("a_valid", kif.key_valid, 1);
      keys[1] = 4'b0000;
      keys[3] = 4'b1000;
      n = 0;
      while (!kif.overflow && n < 200) begin @(negedge clk); n++; end
      chk("overflow_set", kif.overflow, 1);
      chk("a_row_stable", kif.key_row, 1);
      chk("a_col_stable", kif.key_col, 0);
      chk("a_rel_stable", kif.key_release, 0);
      chk("a_valid_stable", kif.key_valid, 1);
      set_ready(1'b1);
      tick(2);
      chk("valid_dropped", kif.key_valid, 0);
      chk("overflow_sticky", kif.overflow, 1);
      wait_ev(nexp, 5);
`ifdef RELEASE_EVENT_EN
      exp_q.push_back('{r: 2'd3, c: 2'd3, rel: 1'b1});
      nexp++;
`endif
      keys[3] = 4'b0000;
      wait_change(4'b1000, n);
      chk("b_release_col", cols, 4'b0001);
      wait_ev(nexp, 10);

      // multi-hot column is ignored
      keys[0] = 4'b0100;
      keys[3] = 4'b0100;
      wait_cols(4'b0010, 40);
      wait_cols(4'b0001, 40);
      for (int k = 0; k < 32; k++) begin
         chk("rotate", cols, 1 << ((k / 4) % 4));
         tick(1);
      end
      keys = '0;
      chk("overflow_still", kif.overflow, 1);

      tick(20);
      chk("events_total", ev_seen, nexp);
      chk("queue_empty", exp_q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
